wb_retire_arbiter: RTL and testbench
====================================

Name: wb_retire_arbiter

Overview:
- Multi-channel successor to the single-channel writeback stage.
- Accepts completed results from NCH execution channels (e.g. ALU, LSU, MUL) over valid/ready handshakes and buffers each in a per-channel FIFO.
- Retires one entry per cycle to the single register-file write port and the fetch redirect port, using round-robin arbitration.
- Maintains a retired-instruction counter.

Parameters:
XLEN, 64, data/address width
NCH, 3, number of result channels (2..8)
DEPTH, 2, entries per channel FIFO (power of 2, >=1)

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous clear of all FIFOs
CH_V  in  NCH  per-channel result valid
CH_RDY  out  NCH  per-channel ready (FIFO not full)
CH_REG_WEN  in  NCH  result writes a register
CH_DR  in  NCH*5  destination register, channel i at [5i+4:5i]
CH_RES  in  NCH*XLEN  result data
CH_PC_MUX  in  NCH  result carries a taken redirect
CH_TARGET  in  NCH*XLEN  redirect target address
OUT_DE_REG_WEN  out  1  register-file write enable
OUT_DE_DR  out  5  register-file write index
OUT_DE_Data  out  XLEN  register-file write data
OUT_FE_PC_MUX  out  1  fetch redirect select
OUT_FE_Target_Address  out  XLEN  fetch redirect target
INSTRET  out  64  retired-entry count

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET_N is asynchronous and active-low.
- Reset values:
  - All FIFOs empty; all outputs 0; INSTRET = 0.
  - Round-robin pointer = NCH-1, so channel 0 has first priority.
- Push:
  - Channel i pushes when CH_V[i] && CH_RDY[i] at a rising edge.
  - The entry stored is {REG_WEN, DR, RES, PC_MUX, TARGET}.
- Ready:
  - CH_RDY[i] = (count_i < DEPTH), taken from registered count only.
  - A full FIFO deasserts ready even in a cycle where it pops; there is no pass-through.
  - CH_RDY is 0 while RESET_N is low.
- Arbitration:
  - Each cycle, select the first non-empty FIFO searching from pointer+1 modulo NCH.
  - Pop its head and set pointer = granted index.
  - At most one pop per cycle; per-channel order is FIFO.
- Output timing:
  - Outputs are registered. An entry pushed at edge N is poppable at edge N+1 at the earliest; outputs reflect it during the cycle after edge N+1.
  - Minimum push-to-output latency is 2 cycles.
- Output values on a retire cycle (outputs valid for exactly one cycle):
  - OUT_DE_REG_WEN = REG_WEN && (DR != 0); x0 writes are suppressed.
  - OUT_DE_DR = DR; OUT_DE_Data = RES.
  - OUT_FE_PC_MUX = PC_MUX; OUT_FE_Target_Address = TARGET.
  - INSTRET increments by 1, wrapping modulo 2^64.
- Output values on a non-retire cycle:
  - OUT_DE_REG_WEN = 0 and OUT_FE_PC_MUX = 0.
  - DR, Data and Target hold their last values.
- FLUSH:
  - At the edge where FLUSH=1, all FIFO counts go to 0.
  - No pop occurs and pushes in that cycle are discarded.
  - Next-cycle OUT_DE_REG_WEN = OUT_FE_PC_MUX = 0.
  - Pointer and INSTRET are unchanged.
- Redirect: the block does not flush on a PC_MUX retire. The front end asserts FLUSH separately.
- Simultaneous push and pop on the same channel (not full): count unchanged; the new entry is appended behind the head.
- Reset mid-operation: all state returns immediately to reset values; buffered entries are lost.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. Count is log2(DEPTH)+1 bits wide.

Test Plan:
- Single retire: reset, then ch0 push {WEN=1, DR=5, RES=0xDEAD}. Required: 2 cycles later OUT_DE_REG_WEN=1, DR=5, Data=0xDEAD for one cycle; INSTRET=1.
- x0 suppression: ch1 push {WEN=1, DR=0, RES=7}. Required: OUT_DE_REG_WEN=0 on the retire cycle and INSTRET still increments.
- Round-robin: NCH=3, preload every FIFO with 2 entries, channel i data = 16i+k. Required: retire order ch0,ch1,ch2,ch0,ch1,ch2 on consecutive cycles; INSTRET=6.
- Backpressure: DEPTH=2, stall arbitration by holding ch0 busy while ch2 pushes 3 times. Required: CH_RDY[2]=0 after 2 accepted pushes; the third is accepted only after a pop; no entry lost or duplicated.
- Redirect and flush: ch1 entry {PC_MUX=1, TARGET=0x8000_0040} with 2 entries queued in ch2; assert FLUSH the cycle after OUT_FE_PC_MUX=1. Required: one-cycle PC_MUX pulse with the target, then ch2 entries never retire.
- Async reset mid-stream: drop RESET_N between clock edges while FIFOs are non-empty. Required: all outputs 0 and CH_RDY=0 immediately; after release the first retire is from ch0 priority.

Source files
------------

// File: rtl/wb_retire_arbiter.sv
// Multi-channel writeback retire stage: per-channel result FIFOs drained one entry
// per cycle, round-robin, into the register-file write port and the fetch redirect port.
module wb_retire_arbiter #(
    parameter int XLEN  = 64,
    parameter int NCH   = 3,
    parameter int DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                FLUSH,
    input  logic [NCH-1:0]      CH_V,
    output logic [NCH-1:0]      CH_RDY,
    input  logic [NCH-1:0]      CH_REG_WEN,
    input  logic [NCH*5-1:0]    CH_DR,
    input  logic [NCH*XLEN-1:0] CH_RES,
    input  logic [NCH-1:0]      CH_PC_MUX,
    input  logic [NCH*XLEN-1:0] CH_TARGET,
    output logic                OUT_DE_REG_WEN,
    output logic [4:0]          OUT_DE_DR,
    output logic [XLEN-1:0]     OUT_DE_Data,
    output logic                OUT_FE_PC_MUX,
    output logic [XLEN-1:0]     OUT_FE_Target_Address,
    output logic [63:0]         INSTRET
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int EW = 2 * XLEN + 7;

    logic [EW-1:0]   mem_q    [NCH][DEPTH];
    logic [PW-1:0]   wr_ptr_q [NCH];
    logic [PW-1:0]   rd_ptr_q [NCH];
    logic [CW-1:0]   count_q  [NCH];
    logic [CW-1:0]   count_d  [NCH];
    logic [EW-1:0]   entry_in [NCH];
    logic [GW-1:0]   rr_q, rr_d, grant;
    logic [NCH-1:0]  push, pop;
    logic            pop_any;
    logic [EW-1:0]   head;

    logic            out_wen_q, out_pc_q;
    logic [4:0]      out_dr_q;
    logic [XLEN-1:0] out_data_q, out_tgt_q;
    logic [63:0]     instret_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on the registered count only, so a full FIFO stays not-ready even while popping.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            CH_RDY[i]   = RESET_N && (count_q[i] < CW'(DEPTH));
            push[i]     = CH_V[i] && CH_RDY[i] && !FLUSH;
            entry_in[i] = {CH_REG_WEN[i], CH_DR[5*i +: 5], CH_RES[XLEN*i +: XLEN],
                           CH_PC_MUX[i], CH_TARGET[XLEN*i +: XLEN]};
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        pop_any = 1'b0;
        grant   = rr_q;
        pop     = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_q) + k) % NCH;
            if (!pop_any && count_q[idx] != '0) begin
                pop_any = 1'b1;
                grant   = GW'(idx);
            end
        end
        if (FLUSH) pop_any = 1'b0;
        if (pop_any) pop[grant] = 1'b1;
        rr_d = pop_any ? grant : rr_q;
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            count_d[i] = count_q[i];
            if (FLUSH)
                count_d[i] = '0;
            else if (push[i] && !pop[i])
                count_d[i] = count_q[i] + 1'b1;
            else if (!push[i] && pop[i])
                count_d[i] = count_q[i] - 1'b1;
        end
    end

    assign head = mem_q[grant][rd_ptr_q[grant]];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
            end
            rr_q       <= GW'(NCH - 1);
            out_wen_q  <= 1'b0;
            out_pc_q   <= 1'b0;
            out_dr_q   <= '0;
            out_data_q <= '0;
            out_tgt_q  <= '0;
            instret_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= count_d[i];
                if (FLUSH) begin
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                end else begin
                    if (push[i]) begin
                        mem_q[i][wr_ptr_q[i]] <= entry_in[i];
                        wr_ptr_q[i]           <= ptr_inc(wr_ptr_q[i]);
                    end
                    if (pop[i]) rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                end
            end
            rr_q <= rr_d;
            if (pop_any) begin
                // Writes to x0 retire normally but never reach the register file.
                out_wen_q  <= head[EW-1] && (head[2*XLEN+5 -: 5] != 5'd0);
                out_dr_q   <= head[2*XLEN+5 -: 5];
                out_data_q <= head[2*XLEN -: XLEN];
                out_pc_q   <= head[XLEN];
                out_tgt_q  <= head[XLEN-1:0];
                instret_q  <= instret_q + 64'd1;
            end else begin
                out_wen_q <= 1'b0;
                out_pc_q  <= 1'b0;
            end
        end
    end

    assign OUT_DE_REG_WEN        = out_wen_q;
    assign OUT_DE_DR             = out_dr_q;
    assign OUT_DE_Data           = out_data_q;
    assign OUT_FE_PC_MUX         = out_pc_q;
    assign OUT_FE_Target_Address = out_tgt_q;
    assign INSTRET               = instret_q;

endmodule

// File: tb/tb_wb_retire_arbiter.sv
// Directed self-checking bench for wb_retire_arbiter (XLEN=64, NCH=3, DEPTH=2).
module tb_wb_retire_arbiter;

    localparam int XLEN  = 64;
    localparam int NCH   = 3;
    localparam int DEPTH = 2;

    logic                CLK = 1'b0;
    logic                RESET_N = 1'b0;
    logic                FLUSH = 1'b0;
    logic [NCH-1:0]      CH_V = '0;
    logic [NCH-1:0]      CH_RDY;
    logic [NCH-1:0]      CH_REG_WEN = '0;
    logic [NCH*5-1:0]    CH_DR = '0;
    logic [NCH*XLEN-1:0] CH_RES = '0;
    logic [NCH-1:0]      CH_PC_MUX = '0;
    logic [NCH*XLEN-1:0] CH_TARGET = '0;
    logic                OUT_DE_REG_WEN;
    logic [4:0]          OUT_DE_DR;
    logic [XLEN-1:0]     OUT_DE_Data;
    logic                OUT_FE_PC_MUX;
    logic [XLEN-1:0]     OUT_FE_Target_Address;
    logic [63:0]         INSTRET;

    int tests_run = 0;
    int errors    = 0;

    wb_retire_arbiter #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
        .CH_V(CH_V), .CH_RDY(CH_RDY), .CH_REG_WEN(CH_REG_WEN), .CH_DR(CH_DR),
        .CH_RES(CH_RES), .CH_PC_MUX(CH_PC_MUX), .CH_TARGET(CH_TARGET),
        .OUT_DE_REG_WEN(OUT_DE_REG_WEN), .OUT_DE_DR(OUT_DE_DR), .OUT_DE_Data(OUT_DE_Data),
        .OUT_FE_PC_MUX(OUT_FE_PC_MUX), .OUT_FE_Target_Address(OUT_FE_Target_Address),
        .INSTRET(INSTRET)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic wen, input logic [4:0] dr,
                          input logic [63:0] res, input logic pc, input logic [63:0] tgt);
        CH_REG_WEN[ch]             = wen;
        CH_DR[ch*5 +: 5]           = dr;
        CH_RES[ch*XLEN +: XLEN]    = res;
        CH_PC_MUX[ch]              = pc;
        CH_TARGET[ch*XLEN +: XLEN] = tgt;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    logic [63:0] rr_data [6] = '{64'd0, 64'd16, 64'd32, 64'd1, 64'd17, 64'd33};
    logic [4:0]  rr_dr   [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_wen", OUT_DE_REG_WEN, 0);
        chk("rst_pc", OUT_FE_PC_MUX, 0);
        chk("rst_data", OUT_DE_Data, 0);
        chk("rst_instret", INSTRET, 0);
        chk("rst_rdy", CH_RDY, 3'b000);
        RESET_N = 1'b1;
        #1;
        chk("rel_rdy", CH_RDY, 3'b111);

        // single retire
        set_ch(0, 1, 5, 64'hDEAD, 0, 0);
        CH_V = 3'b001;
        tick();
        CH_V = 3'b000;
        chk("t1_early_wen", OUT_DE_REG_WEN, 0);
        tick();
        chk("t1_wen", OUT_DE_REG_WEN, 1);
        chk("t1_dr", OUT_DE_DR, 5);
        chk("t1_data", OUT_DE_Data, 64'hDEAD);
        chk("t1_instret", INSTRET, 1);
        tick();
        chk("t1_wen_drop", OUT_DE_REG_WEN, 0);
        chk("t1_dr_hold", OUT_DE_DR, 5);
        chk("t1_instret_hold", INSTRET, 1);

        // x0 suppression
        set_ch(1, 1, 0, 64'd7, 0, 0);
        CH_V = 3'b010;
        tick();
        CH_V = 3'b000;
        tick();
        chk("t2_wen", OUT_DE_REG_WEN, 0);
        chk("t2_data", OUT_DE_Data, 7);
        chk("t2_instret", INSTRET, 2);

        // round-robin over preloaded FIFOs
        do_reset();
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 5'(i + 1), 64'(16 * i), 0, 0);
        CH_V = 3'b111;
        tick();
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 5'(i + 1), 64'(16 * i + 1), 0, 0);
        tick();
        CH_V = 3'b000;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) tick();
            chk($sformatf("t3_wen%0d", n), OUT_DE_REG_WEN, 1);
            chk($sformatf("t3_data%0d", n), OUT_DE_Data, rr_data[n]);
            chk($sformatf("t3_dr%0d", n), OUT_DE_DR, rr_dr[n]);
        end
        chk("t3_instret", INSTRET, 6);
        tick();
        chk("t3_idle_wen", OUT_DE_REG_WEN, 0);

        // backpressure on ch2 while ch0 competes
        do_reset();
        set_ch(0, 1, 4, 64'hA0, 0, 0);
        set_ch(2, 1, 6, 64'hC0, 0, 0);
        CH_V = 3'b101;
        tick();
        chk("t4_rdy_a", CH_RDY[2], 1);
        set_ch(0, 1, 4, 64'hA1, 0, 0);
        set_ch(2, 1, 6, 64'hC1, 0, 0);
        tick();
        chk("t4_rdy_full", CH_RDY[2], 0);
        chk("t4_ret_a0", OUT_DE_Data, 64'hA0);
        CH_V = 3'b100;
        set_ch(2, 1, 6, 64'hC2, 0, 0);
        tick();
        chk("t4_ret_c0", OUT_DE_Data, 64'hC0);
        chk("t4_rdy_after_pop", CH_RDY[2], 1);
        tick();
        CH_V = 3'b000;
        chk("t4_ret_a1", OUT_DE_Data, 64'hA1);
        chk("t4_rdy_full2", CH_RDY[2], 0);
        tick();
        chk("t4_ret_c1", OUT_DE_Data, 64'hC1);
        tick();
        chk("t4_ret_c2", OUT_DE_Data, 64'hC2);
        chk("t4_ret_c2_wen", OUT_DE_REG_WEN, 1);
        tick();
        chk("t4_idle_wen", OUT_DE_REG_WEN, 0);
        chk("t4_instret", INSTRET, 5);

        // redirect then flush
        set_ch(1, 0, 9, 64'h55, 1, 64'h8000_0040);
        set_ch(2, 1, 7, 64'hE0, 0, 64'h1234);
        CH_V = 3'b110;
        tick();
        set_ch(2, 1, 7, 64'hE1, 0, 64'h1234);
        CH_V = 3'b100;
        tick();
        chk("t5_pc", OUT_FE_PC_MUX, 1);
        chk("t5_tgt", OUT_FE_Target_Address, 64'h8000_0040);
        chk("t5_wen", OUT_DE_REG_WEN, 0);
        chk("t5_instret", INSTRET, 6);
        FLUSH = 1'b1;
        set_ch(0, 1, 3, 64'hF0, 1, 64'hBAD);
        CH_V = 3'b001;
        tick();
        FLUSH = 1'b0;
        CH_V = 3'b000;
        chk("t5_flush_pc", OUT_FE_PC_MUX, 0);
        chk("t5_flush_wen", OUT_DE_REG_WEN, 0);
        chk("t5_tgt_hold", OUT_FE_Target_Address, 64'h8000_0040);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("t5_quiet_wen%0d", n), OUT_DE_REG_WEN, 0);
            chk($sformatf("t5_quiet_pc%0d", n), OUT_FE_PC_MUX, 0);
        end
        chk("t5_instret_hold", INSTRET, 6);
        chk("t5_rdy", CH_RDY, 3'b111);

        // asynchronous reset mid-stream
        set_ch(2, 1, 12, 64'h77, 1, 64'h9000);
        set_ch(1, 1, 11, 64'h66, 0, 0);
        CH_V = 3'b110;
        tick();
        CH_V = 3'b000;
        tick();
        chk("t6_pre_wen", OUT_DE_REG_WEN, 1);
        chk("t6_pre_data", OUT_DE_Data, 64'h77);
        chk("t6_pre_pc", OUT_FE_PC_MUX, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_wen", OUT_DE_REG_WEN, 0);
        chk("t6_rst_pc", OUT_FE_PC_MUX, 0);
        chk("t6_rst_data", OUT_DE_Data, 0);
        chk("t6_rst_dr", OUT_DE_DR, 0);
        chk("t6_rst_tgt", OUT_FE_Target_Address, 0);
        chk("t6_rst_instret", INSTRET, 0);
        chk("t6_rst_rdy", CH_RDY, 3'b000);
        tick();
        RESET_N = 1'b1;
        set_ch(0, 1, 1, 64'h111, 0, 0);
        set_ch(2, 1, 2, 64'h222, 0, 0);
        CH_V = 3'b101;
        tick();
        CH_V = 3'b000;
        tick();
        chk("t6_first_data", OUT_DE_Data, 64'h111);
        chk("t6_first_dr", OUT_DE_DR, 1);
        tick();
        chk("t6_second_data", OUT_DE_Data, 64'h222);
        tick();
        chk("t6_idle_wen", OUT_DE_REG_WEN, 0);
        chk("t6_instret", INSTRET, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
